// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - measurement result bus published by pwm_capture
interface pwm_capture_if #(
   parameter int WIDTH = 26
);
   logic [WIDTH-1:0] duty_out;
   logic [WIDTH-1:0] period_out;
   logic             valid;
   logic             timeout;
   logic             stuck_high;

   modport master (output duty_out, period_out, valid, timeout, stuck_high);
   modport slave  (input  duty_out, period_out, valid, timeout, stuck_high);
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time / period meter with loss-of-signal detection
// Counts in clk cycles between synchronized edges; reports once per period.
module pwm_capture #(
   parameter int WIDTH   = 26,
   parameter int TIMEOUT = 2100000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pwm_in,
   pwm_capture_if.master res
);
   typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

   localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   logic             s1_q, s2_q, s3_q;
   state_t           state_q;
   logic [WIDTH-1:0] per_cnt_q, hi_cnt_q;
   logic [WIDTH-1:0] per_cnt_d, hi_cnt_d;
   logic [WIDTH-1:0] duty_q, period_q;
   logic             valid_q, timeout_q, stuck_q;

   logic rise, fall, at_limit, do_report, do_timeout;

   assign rise     = s2_q & ~s3_q;
   assign fall     = ~s2_q & s3_q;
   assign at_limit = (per_cnt_q == LIMIT);

   // A rise always beats the timeout; in IDLE the timeout fires only once.
   assign do_report  = (state_q == MEAS_LOW) && rise;
   assign do_timeout = at_limit && !rise && ((state_q != IDLE) || !timeout_q);

   always_comb begin
      per_cnt_d = per_cnt_q;
      hi_cnt_d  = hi_cnt_q;
      if (rise) begin
         per_cnt_d = ONE;
         hi_cnt_d  = ONE;
      end else begin
         if (!at_limit) per_cnt_d = per_cnt_q + ONE;
         if ((state_q == MEAS_HIGH) && !fall) hi_cnt_d = hi_cnt_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         state_q   <= IDLE;
         per_cnt_q <= '0;
         hi_cnt_q  <= '0;
         duty_q    <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         stuck_q   <= 1'b0;
      end else begin
         s1_q      <= pwm_in;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         per_cnt_q <= per_cnt_d;
         hi_cnt_q  <= hi_cnt_d;
         valid_q   <= do_report | do_timeout;
         if (do_timeout) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
            stuck_q   <= s2_q;
            duty_q    <= '0;
            period_q  <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (rise) state_q <= MEAS_HIGH;
               end
               MEAS_HIGH: begin
                  if (fall) state_q <= MEAS_LOW;
               end
               MEAS_LOW: begin
                  if (rise) begin
                     state_q   <= MEAS_HIGH;
                     period_q  <= per_cnt_q;
                     duty_q    <= hi_cnt_q;
                     timeout_q <= 1'b0;
                     stuck_q   <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign res.duty_out   = duty_q;
   assign res.period_out = period_q;
   assign res.valid      = valid_q;
   assign res.timeout    = timeout_q;
   assign res.stuck_high = stuck_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;
   localparam int W  = 12;
   localparam int TO = 300;

   typedef struct {
      int roll;
      int duty;
      int nper;
      int exp_d;
      int exp_p;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pwm = 1'b0;

   always #5 clk = ~clk;

   pwm_capture_if #(.WIDTH(W)) res_if ();

   pwm_capture #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm),
      .res    (res_if)
   );

   int checks = 0;
   int errors = 0;
   int vcnt   = 0;
   int n_to   = 0;
   int mcount = 0;
   int tgt_d  = 0;
   int tgt_p  = 0;

   int edge_n = 0;
   int base_e = 0;
   int rise_t = 0;
   int fall_t = -1;
   bit have_rise  = 1'b0;
   bit seen_reset = 1'b0;
   bit m_s1 = 1'b0, m_s2 = 1'b0, m_s3 = 1'b0;
   int exp_duty = 0, exp_period = 0;
   bit exp_valid = 1'b0, exp_to = 1'b0, exp_stuck = 1'b0;

   // Reference: timestamps of synchronized edges; results are edge-time differences.
   initial begin : model
      bit r, f;
      int elapsed;
      forever begin
         @(posedge clk);
         edge_n++;
         if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
            base_e = edge_n; have_rise = 1'b0; fall_t = -1;
            exp_valid = 1'b0; exp_to = 1'b0; exp_stuck = 1'b0;
            exp_duty = 0; exp_period = 0;
            seen_reset = 1'b1;
         end else begin
            r = m_s2 && !m_s3;
            f = !m_s2 && m_s3;
            elapsed = edge_n - 1 - base_e;
            exp_valid = 1'b0;
            if (r) begin
               if (have_rise && fall_t >= 0) begin
                  exp_period = edge_n - rise_t;
                  exp_duty   = fall_t - rise_t;
                  exp_valid  = 1'b1;
                  exp_to     = 1'b0;
                  exp_stuck  = 1'b0;
               end
               have_rise = 1'b1;
               rise_t    = edge_n;
               fall_t    = -1;
               base_e    = edge_n - 1;
            end else if (elapsed == TO && (have_rise || !exp_to)) begin
               exp_valid  = 1'b1;
               exp_to     = 1'b1;
               exp_stuck  = m_s2;
               exp_duty   = 0;
               exp_period = 0;
               have_rise  = 1'b0;
               fall_t     = -1;
            end else if (f && have_rise && fall_t < 0) begin
               fall_t = edge_n;
            end
            m_s3 = m_s2;
            m_s2 = m_s1;
            m_s1 = pwm;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (seen_reset) begin
            checks++;
            if (res_if.valid !== exp_valid || res_if.duty_out !== exp_duty[W-1:0] ||
                res_if.period_out !== exp_period[W-1:0] || res_if.timeout !== exp_to ||
                res_if.stuck_high !== exp_stuck) begin
               errors++;
               $display("FAIL model edge=%0d valid=%0b want %0b duty=%0d want %0d period=%0d want %0d timeout=%0b want %0b stuck=%0b want %0b",
                        edge_n, res_if.valid, exp_valid, res_if.duty_out, exp_duty,
                        res_if.period_out, exp_period, res_if.timeout, exp_to,
                        res_if.stuck_high, exp_stuck);
            end
            if (res_if.valid === 1'b1) begin
               vcnt++;
               if (res_if.timeout) n_to++;
               else if (int'(res_if.duty_out) == tgt_d && int'(res_if.period_out) == tgt_p) mcount++;
            end
         end
      end
   end

   task automatic tick(input logic p);
      @(posedge clk);
      #1;
      pwm = p;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string name, input int d, input int p, input int v,
                                input int t, input int s);
      check({name, "_duty"},    int'(res_if.duty_out),   d);
      check({name, "_period"},  int'(res_if.period_out), p);
      check({name, "_valid"},   int'(res_if.valid),      v);
      check({name, "_timeout"}, int'(res_if.timeout),    t);
      check({name, "_stuck"},   int'(res_if.stuck_high), s);
   endtask

   task automatic run_gen(input int roll, input int duty, input int nper);
      for (int k = 0; k < nper; k++)
         for (int c = 0; c <= roll; c++)
            tick(c < duty);
   endtask

   initial begin : main
      vec_t tbl[8];
      int first, v0, jn, jt, t0;

      tbl[0] = '{200, 5,  4, 5,  201};
      tbl[1] = '{9,   1,  6, 1,  10};
      tbl[2] = '{99,  10, 3, 10, 100};
      tbl[3] = '{99,  90, 3, 90, 100};
      tbl[4] = '{49,  25, 4, 25, 50};
      tbl[5] = '{29,  28, 3, 28, 30};
      tbl[6] = '{19,  19, 3, 19, 20};
      tbl[7] = '{TO - 1, 7, 3, 7, TO};

      rst = 1'b1;
      pwm = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;

      // Constant low from reset: a single timeout report, then silence.
      v0 = vcnt;
      first = -1;
      for (int n = 1; n <= TO + 40; n++) begin
         tick(1'b0);
         if (res_if.valid && first < 0) begin
            first = n;
            check_outputs("to_low", 0, 0, 1, 1, 0);
         end
      end
      check("to_low_at", first, TO + 1);
      check("to_low_single", vcnt - v0, 1);

      foreach (tbl[i]) begin
         tgt_d  = tbl[i].exp_d;
         tgt_p  = tbl[i].exp_p;
         mcount = 0;
         run_gen(tbl[i].roll, tbl[i].duty, tbl[i].nper);
         check($sformatf("tbl%0d_reports", i), mcount, tbl[i].nper - 1);
         check($sformatf("tbl%0d_duty", i), int'(res_if.duty_out), tbl[i].exp_d);
         check($sformatf("tbl%0d_period", i), int'(res_if.period_out), tbl[i].exp_p);
      end

      // Constant high: last rise reports normally, timeout follows TO cycles later.
      jn = -1;
      jt = -1;
      t0 = n_to;
      for (int j = 1; j <= TO + 30; j++) begin
         tick(1'b1);
         if (res_if.valid) begin
            if (res_if.timeout) jt = j;
            else if (jn < 0) jn = j;
         end
      end
      check("stuck_rise_at", jn, 4);
      check("stuck_to_gap", jt - jn, TO);
      check("stuck_to_count", n_to - t0, 1);
      check_outputs("stuck", 0, 0, 0, 1, 1);

      v0 = vcnt;
      tgt_d = 24;
      tgt_p = 100;
      mcount = 0;
      run_gen(99, 24, 3);
      check("restore_valids", vcnt - v0, 1);
      check("restore_reports", mcount, 1);
      check_outputs("restore", 24, 100, 0, 0, 0);

      // Reset in the middle of a high phase.
      run_gen(49, 30, 2);
      repeat (10) tick(1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("midrst", 0, 0, 0, 0, 0);
      rst = 1'b0;
      v0 = vcnt;
      repeat (20) tick(1'b1);
      repeat (20) tick(1'b0);
      check("midrst_no_valid", vcnt - v0, 0);
      tgt_d = 30;
      tgt_p = 50;
      mcount = 0;
      run_gen(49, 30, 3);
      check("midrst_reports", mcount, 2);
      check("midrst_duty", int'(res_if.duty_out), 30);

      for (int i = 0; i < 40; i++) begin
         int hi, lo;
         hi = $urandom_range(1, 40);
         if ($urandom_range(0, 7) == 0) lo = $urandom_range(TO - 6, TO + 6);
         else lo = $urandom_range(1, 40);
         repeat (hi) tick(1'b1);
         repeat (lo) tick(1'b0);
         if ($urandom_range(0, 14) == 0) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
         end
      end
      repeat (10) tick(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
